// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared FSM state type, limits and the round-robin search used by the bus arbiter
package prll_bs_pkg;
  typedef enum logic [1:0] {IDLE, POP, PUSH} prll_bs_state_t;
  localparam int ID_BITS_DFLT = 8;
  localparam int MAX_DRVRS = 32;
  localparam int PW = $clog2(MAX_DRVRS);
  function automatic logic [PW-1:0] rr_next(input logic [MAX_DRVRS-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] idx;
    rr_next = ptr;
    for (int k = MAX_DRVRS; k >= 1; k--) begin
      idx = ptr + PW'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/prll_bs_rr_pick.sv
// prll_bs_rr_pick: combinational round-robin picker (req, ptr -> win index, any request)
module prll_bs_rr_pick
  import prll_bs_pkg::*;
#(
  parameter int drvrs = 7
) (
  input  logic [drvrs-1:0]         req,
  input  logic [$clog2(drvrs)-1:0] ptr,
  output logic [$clog2(drvrs)-1:0] win,
  output logic                     any
);
  localparam int pw = $clog2(drvrs);
  assign win = pw'(rr_next(MAX_DRVRS'(req), PW'(ptr)));
  assign any = |req;
endmodule

// File: rtl/prll_bs_rr_rbtr.sv
// prll_bs_rr_rbtr: round-robin shared-bus arbiter; clk/reset(async low), pndng+D_pop in, pop/push/D_push/drop out; broadcast via PRLL_BS_BROADCAST_EN
module prll_bs_rr_rbtr
  import prll_bs_pkg::*;
#(
  parameter int                 drvrs     = 7,
  parameter int                 bits      = 256,
  parameter int                 id_bits   = ID_BITS_DFLT,
  parameter logic [id_bits-1:0] broadcast = {id_bits{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [drvrs-1:0]        pndng,
  input  logic [drvrs*bits-1:0]   D_pop,
  output logic [drvrs-1:0]        pop,
  output logic [drvrs-1:0]        push,
  output logic [drvrs*bits-1:0]   D_push,
  output logic                    drop
);
  localparam int pw = $clog2(drvrs);
  localparam int iw = id_bits > 6 ? id_bits : 6;
`ifdef PRLL_BS_BROADCAST_EN
  localparam logic bc_en = 1'b1;
`else
  localparam logic bc_en = 1'b0;
`endif
  prll_bs_state_t    state;
  logic [pw-1:0]     ptr, w, win;
  logic              any, uni, bc;
  logic [bits-1:0]   data_q, head;
  logic [id_bits-1:0] dst;
  logic [drvrs-1:0]  pat;
  prll_bs_rr_pick #(.drvrs(drvrs)) u_pick (
    .req(pndng),
    .ptr(state == PUSH ? w : ptr),
    .win(win),
    .any(any)
  );
  assign head = D_pop[int'(w)*bits +: bits];
  assign dst = head[bits-1 -: id_bits];
  assign bc = bc_en && dst == broadcast;
  assign uni = iw'(dst) < iw'(drvrs);
  assign pat = bc ? ~(drvrs'(1) << w) : uni ? drvrs'(1) << dst : '0;
  assign D_push = {drvrs{data_q}};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= pw'(drvrs - 1);
      w <= '0;
      pop <= '0;
      push <= '0;
      drop <= 1'b0;
      data_q <= '0;
    end else begin
      pop <= '0;
      push <= '0;
      drop <= 1'b0;
      case (state)
        IDLE, PUSH: begin
          if (state == PUSH) ptr <= w;
          state <= any ? POP : IDLE;
          if (any) begin
            w <= win;
            pop <= drvrs'(1) << win;
          end
        end
        POP: begin
          data_q <= head;
          push <= pat;
          drop <= ~|pat;
          state <= PUSH;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
